// File: rtl/cgra_config_loader_if.sv
// ---------------------------------------------------------------------------
// cgra_config_loader_if
//   Upstream configuration-word channel feeding the CGRA config loader.
//
//   Handshake: the source drives in_valid together with a stable word; the
//   word transfers in any cycle where in_valid=1 and in_stop=0 at the rising
//   clock edge. While in_stop=1 the source must hold in_valid and every field
//   unchanged; the word is not consumed.
//
//   Signals (master = word source, slave = loader):
//     in_valid    word present
//     in_stop     loader refuses the word this cycle
//     in_row      target PE row
//     in_col      target PE column
//     in_src1/2   operand source selects
//     in_out_mask output neighbour mask
//     in_op       opcode
//     in_const    constant operand
//     in_ctx      context index
// ---------------------------------------------------------------------------
interface cgra_config_loader_if #(
  parameter int ROW_W  = 2,
  parameter int COL_W  = 2,
  parameter int SRC_W  = 3,
  parameter int MASK_W = 4,
  parameter int OP_W   = 4,
  parameter int DATA_W = 32,
  parameter int CTX_W  = 3
);
  logic              in_valid;
  logic              in_stop;
  logic [ROW_W-1:0]  in_row;
  logic [COL_W-1:0]  in_col;
  logic [SRC_W-1:0]  in_src1;
  logic [SRC_W-1:0]  in_src2;
  logic [MASK_W-1:0] in_out_mask;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_const;
  logic [CTX_W-1:0]  in_ctx;

  modport master (
    output in_valid, in_row, in_col, in_src1, in_src2,
           in_out_mask, in_op, in_const, in_ctx,
    input  in_stop
  );

  modport slave (
    input  in_valid, in_row, in_col, in_src1, in_src2,
           in_out_mask, in_op, in_const, in_ctx,
    output in_stop
  );
endinterface

// File: rtl/cgra_config_loader.sv
// ---------------------------------------------------------------------------
// cgra_config_loader
//   Streams a counted sequence of configuration words from an upstream
//   channel into the CGRA configuration port, then pulses start_exec.
//   Each accepted word is range-checked (row, column, context); a bad word
//   stops the load in a sticky ERROR state until the next load_start.
//
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     load_start              begin a load (only honoured in IDLE/DONE/ERROR)
//     num_entries             words to load (0 goes straight to START)
//     context_max_id          highest legal context index for this load
//     up                      upstream word channel (slave side)
//     config_*                registered word fields toward the PE array
//     write_config_data       one-cycle write strobe for config_*
//     start_exec              one-cycle execution start pulse
//     mapping_context_max_id  latched context_max_id
//     loaded_count            words written so far in this load
//     busy / done / error     status
//     state_dbg               current FSM state
// ---------------------------------------------------------------------------
module cgra_config_loader #(
  parameter int PE_ROW_SIZE             = 4,
  parameter int PE_COLUMN_SIZE          = 4,
  parameter int NEIGHBOR_PE_NUM         = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int OPERATION_BIT_LENGTH    = 4,
  parameter int INPUT_NUM_BIT_LENGTH    = 3,
  parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
  parameter int ENTRY_COUNT_WIDTH       = 8,
  localparam int ROW_W = (PE_ROW_SIZE    > 1) ? $clog2(PE_ROW_SIZE)    : 1,
  localparam int COL_W = (PE_COLUMN_SIZE > 1) ? $clog2(PE_COLUMN_SIZE) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load_start,
  input  logic [ENTRY_COUNT_WIDTH-1:0]       num_entries,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_max_id,
  cgra_config_loader_if.slave                up,
  output logic [ROW_W-1:0]                   config_PE_row_index,
  output logic [COL_W-1:0]                   config_PE_column_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic                               write_config_data,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic [ENTRY_COUNT_WIDTH-1:0]       loaded_count,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [2:0]                         state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]                   state;
  logic [ENTRY_COUNT_WIDTH-1:0] num_q;
  logic                         take;
  logic                         word_ok;
  logic                         last_word;

  // The channel is only open in LOAD, so in_stop doubles as "not loading".
  assign up.in_stop = (state != S_LOAD);
  assign take       = (state == S_LOAD) && up.in_valid;

  // Non-power-of-two array sizes leave field codes that address no PE.
  assign word_ok = (int'(up.in_row) < PE_ROW_SIZE) &&
                   (int'(up.in_col) < PE_COLUMN_SIZE) &&
                   (up.in_ctx <= mapping_context_max_id);

  // LOAD is only entered with num_q > 0 and the count stops at num_q, so
  // this increment never overflows.
  assign last_word = (loaded_count + ENTRY_COUNT_WIDTH'(1)) == num_q;

  assign busy       = (state == S_LOAD) || (state == S_FLUSH) || (state == S_START);
  assign done       = (state == S_DONE);
  assign start_exec = (state == S_START);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= S_IDLE;
      num_q                   <= '0;
      loaded_count            <= '0;
      mapping_context_max_id  <= '0;
      error                   <= 1'b0;
      write_config_data       <= 1'b0;
      config_PE_row_index     <= '0;
      config_PE_column_index  <= '0;
      config_input_PE_index_1 <= '0;
      config_input_PE_index_2 <= '0;
      config_output_PE_index  <= '0;
      config_op               <= '0;
      config_const_data       <= '0;
      config_index            <= '0;
    end else begin
      write_config_data <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            num_q                  <= num_entries;
            mapping_context_max_id <= context_max_id;
            loaded_count           <= '0;
            error                  <= 1'b0;
            state                  <= (num_entries != '0) ? S_LOAD : S_START;
          end
        end
        S_LOAD: begin
          if (take) begin
            if (word_ok) begin
              config_PE_row_index     <= up.in_row;
              config_PE_column_index  <= up.in_col;
              config_input_PE_index_1 <= up.in_src1;
              config_input_PE_index_2 <= up.in_src2;
              config_output_PE_index  <= up.in_out_mask;
              config_op               <= up.in_op;
              config_const_data       <= up.in_const;
              config_index            <= up.in_ctx;
              write_config_data       <= 1'b1;
              loaded_count            <= loaded_count + ENTRY_COUNT_WIDTH'(1);
              if (last_word) begin
                state <= S_FLUSH;
              end
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        // FLUSH covers the cycle in which the final strobe is on the port.
        S_FLUSH: state <= S_START;
        S_START: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_config_loader.sv
// ---------------------------------------------------------------------------
// tb_cgra_config_loader
//   Randomised bench for cgra_config_loader with a 3x4 PE array so that an
//   unaddressable row code exists. A load-level reference model predicts
//   strobes (pushed into exp_q with their due cycle) and per-cycle status;
//   a monitor pops and compares every strobe and checks config hold.
// ---------------------------------------------------------------------------
module tb_cgra_config_loader;

  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int NB   = 4;
  localparam int DW   = 32;
  localparam int OPW  = 4;
  localparam int SRCW = 3;
  localparam int CTXW = 3;
  localparam int ECW  = 8;
  localparam int RW   = 2;
  localparam int CW   = 2;
  localparam int FW   = RW + CW + 2 * SRCW + NB + OPW + DW + CTXW;
  localparam int W    = 32 + FW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT ----------------
  logic            load_start;
  logic [ECW-1:0]  num_entries;
  logic [CTXW-1:0] context_max_id;
  logic [RW-1:0]   config_PE_row_index;
  logic [CW-1:0]   config_PE_column_index;
  logic [SRCW-1:0] config_input_PE_index_1;
  logic [SRCW-1:0] config_input_PE_index_2;
  logic [NB-1:0]   config_output_PE_index;
  logic [OPW-1:0]  config_op;
  logic [DW-1:0]   config_const_data;
  logic [CTXW-1:0] config_index;
  logic            write_config_data;
  logic            start_exec;
  logic [CTXW-1:0] mapping_context_max_id;
  logic [ECW-1:0]  loaded_count;
  logic            busy;
  logic            done;
  logic            error;
  logic [2:0]      state_dbg;

  cgra_config_loader_if #(
    .ROW_W(RW), .COL_W(CW), .SRC_W(SRCW), .MASK_W(NB),
    .OP_W(OPW), .DATA_W(DW), .CTX_W(CTXW)
  ) up_if ();

  cgra_config_loader #(
    .PE_ROW_SIZE(ROWS), .PE_COLUMN_SIZE(COLS), .NEIGHBOR_PE_NUM(NB),
    .DATA_WIDTH(DW), .OPERATION_BIT_LENGTH(OPW), .INPUT_NUM_BIT_LENGTH(SRCW),
    .CONTEXT_SIZE_BIT_LENGTH(CTXW), .ENTRY_COUNT_WIDTH(ECW)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .load_start             (load_start),
    .num_entries            (num_entries),
    .context_max_id         (context_max_id),
    .up                     (up_if),
    .config_PE_row_index    (config_PE_row_index),
    .config_PE_column_index (config_PE_column_index),
    .config_input_PE_index_1(config_input_PE_index_1),
    .config_input_PE_index_2(config_input_PE_index_2),
    .config_output_PE_index (config_output_PE_index),
    .config_op              (config_op),
    .config_const_data      (config_const_data),
    .config_index           (config_index),
    .write_config_data      (write_config_data),
    .start_exec             (start_exec),
    .mapping_context_max_id (mapping_context_max_id),
    .loaded_count           (loaded_count),
    .busy                   (busy),
    .done                   (done),
    .error                  (error),
    .state_dbg              (state_dbg)
  );

  logic [FW-1:0] cfg_word;
  assign cfg_word = {config_PE_row_index, config_PE_column_index,
                     config_input_PE_index_1, config_input_PE_index_2,
                     config_output_PE_index, config_op, config_const_data,
                     config_index};

  // ---------------- scoreboard / counters ----------------
  logic [W-1:0] exp_q[$];   // {due cycle, word}
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 loading, 2 finishing (START at m_start_cyc, DONE after), 3 error
  int m_phase = 0;
  int m_n = 0;
  int m_cnt = 0;
  int m_cmax = 0;
  int m_start_cyc = 0;

  function automatic bit model_busy();
    return (m_phase == 1) || (m_phase == 2 && cyc <= m_start_cyc);
  endfunction

  function automatic logic [FW-1:0] make_word(input int row, input int col, input int ctx);
    logic [RW-1:0]   r = RW'(row);
    logic [CW-1:0]   c = CW'(col);
    logic [SRCW-1:0] s1 = SRCW'($urandom_range(0, 7));
    logic [SRCW-1:0] s2 = SRCW'($urandom_range(0, 7));
    logic [NB-1:0]   mk = NB'($urandom_range(0, 15));
    logic [OPW-1:0]  op = OPW'($urandom_range(0, 15));
    logic [DW-1:0]   k = $urandom;
    logic [CTXW-1:0] x = CTXW'(ctx);
    return {r, c, s1, s2, mk, op, k, x};
  endfunction

  function automatic logic [FW-1:0] rand_word(input bit bad);
    if (!bad)
      return make_word($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
                       $urandom_range(0, m_cmax));
    if (m_cmax == 7 || $urandom_range(0, 1) == 0)
      return make_word(3, $urandom_range(0, COLS - 1), $urandom_range(0, m_cmax));
    return make_word($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
                     $urandom_range(m_cmax + 1, 7));
  endfunction

  // Word handed over at the edge following observation cycle c.
  task automatic model_accept(input logic [FW-1:0] w, input int c);
    int row = int'(w[FW-1 -: RW]);
    int col = int'(w[FW-RW-1 -: CW]);
    int ctx = int'(w[CTXW-1:0]);
    if (m_phase == 1) begin
      if (row < ROWS && col < COLS && ctx <= m_cmax) begin
        exp_q.push_back({32'(c + 1), w});
        m_cnt++;
        if (m_cnt == m_n) begin
          m_phase     = 2;
          m_start_cyc = c + 2;
        end
      end else begin
        m_phase = 3;
      end
    end
  endtask

  task automatic check_status();
    bit e_busy  = (m_phase == 1) || (m_phase == 2 && cyc <= m_start_cyc);
    bit e_done  = (m_phase == 2 && cyc > m_start_cyc);
    bit e_start = (m_phase == 2 && cyc == m_start_cyc);
    bit e_err   = (m_phase == 3);
    bit e_stop  = (m_phase != 1);
    chk("busy", 128'(busy), 128'(e_busy));
    chk("done", 128'(done), 128'(e_done));
    chk("start_exec", 128'(start_exec), 128'(e_start));
    chk("error", 128'(error), 128'(e_err));
    chk("in_stop", 128'(up_if.in_stop), 128'(e_stop));
    chk("loaded_count", 128'(loaded_count), 128'(m_cnt));
    chk("ctx_max", 128'(mapping_context_max_id), 128'(m_cmax));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_stop"}, 128'(up_if.in_stop), 128'(1));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_error"}, 128'(error), 128'(0));
    chk({tag, "_start"}, 128'(start_exec), 128'(0));
    chk({tag, "_strobe"}, 128'(write_config_data), 128'(0));
    chk({tag, "_count"}, 128'(loaded_count), 128'(0));
    chk({tag, "_ctxmax"}, 128'(mapping_context_max_id), 128'(0));
    chk({tag, "_config"}, 128'(cfg_word), 128'(0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_status();
      up_if.in_valid = 1'b0;
      load_start     = 1'b0;
    end
  endtask

  task automatic start_load(input int n, input int cmax);
    @(negedge clk);
    check_status();
    up_if.in_valid = 1'b0;
    num_entries    = ECW'(n);
    context_max_id = CTXW'(cmax);
    load_start     = 1'b1;
    if (!model_busy()) begin
      m_n    = n;
      m_cmax = cmax;
      m_cnt  = 0;
      if (n == 0) begin
        m_phase     = 2;
        m_start_cyc = cyc + 1;
      end else begin
        m_phase = 1;
      end
    end
  endtask

  // Presents w and holds it until taken or max_wait cycles pass.
  task automatic send_word(input logic [FW-1:0] w, input int max_wait);
    bit took = 1'b0;
    for (int i = 0; i < max_wait && !took; i++) begin
      @(negedge clk);
      check_status();
      load_start = 1'b0;
      {up_if.in_row, up_if.in_col, up_if.in_src1, up_if.in_src2,
       up_if.in_out_mask, up_if.in_op, up_if.in_const, up_if.in_ctx} = w;
      up_if.in_valid = 1'b1;
      if (up_if.in_stop == 1'b0) begin
        took = 1'b1;
        model_accept(w, cyc);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    check_status();
    up_if.in_valid = 1'b0;
    load_start     = 1'b0;
    #2 reset_n = 1'b0;
    m_phase = 0; m_cnt = 0; m_cmax = 0; m_n = 0;
    exp_q.delete();
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [FW-1:0] last_w;
    logic [W-1:0]  e;
    last_w = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_w = '0;
      end else if (write_config_data) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL strobe_unexpected: got strobe at cycle %0d want none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe", 128'({32'(cyc), cfg_word}), 128'(e));
          last_w = e[FW-1:0];
        end
      end else begin
        chk("config_hold", 128'(cfg_word), 128'(last_w));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n        = 1'b0;
    load_start     = 1'b0;
    num_entries    = '0;
    context_max_id = '0;
    up_if.in_valid = 1'b0;
    {up_if.in_row, up_if.in_col, up_if.in_src1, up_if.in_src2,
     up_if.in_out_mask, up_if.in_op, up_if.in_const, up_if.in_ctx} = '0;
    cyc = 0;

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Words offered before any load must be refused.
    send_word(rand_word(1'b0), 3);
    idle(1);

    // Three back-to-back words, contexts 0,1,0.
    start_load(3, 1);
    send_word(make_word(0, 1, 0), 4);
    send_word(make_word(2, 3, 1), 4);
    send_word(make_word(1, 0, 0), 4);
    idle(5);

    // Empty load.
    start_load(0, 2);
    idle(4);

    // Gapped words.
    start_load(2, 3);
    send_word(rand_word(1'b0), 4);
    idle(2);
    send_word(rand_word(1'b0), 4);
    idle(5);

    // Context out of range, refusal while in error, recovery.
    start_load(3, 2);
    send_word(make_word(1, 1, 2), 4);
    send_word(make_word(1, 1, 3), 4);
    idle(3);
    send_word(make_word(0, 0, 0), 2);
    idle(1);
    start_load(1, 2);
    send_word(make_word(2, 2, 1), 4);
    idle(5);

    // Unaddressable row.
    start_load(2, 7);
    send_word(make_word(3, 0, 0), 4);
    idle(3);

    // load_start during LOAD is ignored.
    start_load(4, 5);
    send_word(rand_word(1'b0), 4);
    send_word(rand_word(1'b0), 4);
    start_load(9, 0);
    send_word(rand_word(1'b0), 4);
    idle(1);
    send_word(rand_word(1'b0), 4);
    idle(5);

    // Reset after one of four words.
    start_load(4, 3);
    send_word(rand_word(1'b0), 4);
    idle(2);
    pulse_reset();
    idle(2);
    send_word(rand_word(1'b0), 2);
    idle(1);
    start_load(2, 3);
    send_word(rand_word(1'b0), 4);
    send_word(rand_word(1'b0), 4);
    idle(5);

    // Random loads.
    for (int l = 0; l < 40; l++) begin
      int n = $urandom_range(0, 6);
      start_load(n, $urandom_range(0, 7));
      for (int i = 0; i < n; i++) begin
        int gap = $urandom_range(0, 2);
        if (gap > 0) idle(gap);
        send_word(rand_word($urandom_range(0, 19) == 0), 4);
        if (m_phase != 1) break;
      end
      idle(4 + $urandom_range(0, 2));
    end

    idle(3);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cgra_config_loader.md
CGRA_CONFIG_LOADER -- requirements
Module: cgra_config_loader

Interface
REQ-001 Parameters, one per line: name, default, meaning. PE_ROW_SIZE, 4, PE array rows; PE_COLUMN_SIZE, 4, PE array columns; NEIGHBOR_PE_NUM, 4, neighbour links per PE; DATA_WIDTH, 32, constant width; OPERATION_BIT_LENGTH, 4, opcode width; INPUT_NUM_BIT_LENGTH, 3, source-select width; CONTEXT_SIZE_BIT_LENGTH, 3, context index width; ENTRY_COUNT_WIDTH, 8, entry counter width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 system clock; reset_n input 1 asynchronous active-low reset.
REQ-003 Control ports: load_start in 1 begin a load; num_entries in ENTRY_COUNT_WIDTH words to load; context_max_id in CONTEXT_SIZE_BIT_LENGTH last valid context.
REQ-004 Upstream SELF port: in_valid in 1 word present; in_stop out 1 loader refuses word; in_row in clog2(PE_ROW_SIZE); in_col in clog2(PE_COLUMN_SIZE); in_src1, in_src2 in INPUT_NUM_BIT_LENGTH; in_out_mask in NEIGHBOR_PE_NUM; in_op in OPERATION_BIT_LENGTH; in_const in DATA_WIDTH; in_ctx in CONTEXT_SIZE_BIT_LENGTH.
REQ-005 CGRA config port, all registered outputs: config_PE_row_index, config_PE_column_index, config_input_PE_index_1, config_input_PE_index_2, config_output_PE_index, config_op, config_const_data, config_index (widths as matching in_* fields); write_config_data out 1 write strobe.
REQ-006 Execution/status outputs: start_exec out 1; mapping_context_max_id out CONTEXT_SIZE_BIT_LENGTH; loaded_count out ENTRY_COUNT_WIDTH; busy out 1; done out 1; error out 1.

Function
REQ-007 FSM states: IDLE, LOAD, FLUSH, START, DONE, ERROR.
REQ-008 A word SHALL transfer in any cycle with in_valid=1 and in_stop=0; in_stop SHALL be 0 only in LOAD.
REQ-009 IDLE/DONE/ERROR + load_start=1: latch num_entries and context_max_id (context_max_id drives mapping_context_max_id), clear loaded_count, clear done/error; go LOAD if num_entries>0, else START.
REQ-010 load_start SHALL be ignored in LOAD, FLUSH and START.
REQ-011 Transfer in cycle t with in_row<PE_ROW_SIZE, in_col<PE_COLUMN_SIZE, in_ctx<=latched context_max_id: config_* SHALL carry the word fields and write_config_data=1 in cycle t+1 only; loaded_count increments at t+1.
REQ-012 Latency in->config strobe SHALL be exactly 1 cycle; back-to-back transfers SHALL produce back-to-back strobes, full throughput.
REQ-013 Transfer of the word making loaded_count equal num_entries: state FLUSH at t+1 (its strobe), START at t+2 with start_exec=1 for that one cycle, DONE at t+3.
REQ-014 Out-of-range word (row, col or ctx per REQ-011): no strobe, loaded_count unchanged, state ERROR next cycle, error=1 sticky until next load_start or reset.
REQ-015 config_* SHALL hold last written values when write_config_data=0.
REQ-016 busy=1 in LOAD, FLUSH, START; done=1 in DONE; start_exec=1 only in START.
REQ-017 loaded_count SHALL never exceed num_entries; no wrap occurs since the count stops at num_entries.
REQ-018 in_valid with in_stop=1 SHALL NOT consume the word; upstream holds it.

Reset
REQ-019 reset_n=0 at any time, including mid-load, SHALL immediately force IDLE and drive all outputs 0 except in_stop=1; no strobe or start_exec SHALL be issued for any partially loaded sequence.
REQ-020 After reset release, the block SHALL accept no words until load_start.

Verification
REQ-021 num_entries=3, context_max_id=1, three valid words back-to-back (ctx 0,1,0) -> strobes in 3 consecutive cycles matching fields, FLUSH then start_exec pulse 2 cycles after last transfer, done=1, loaded_count=3.
REQ-022 num_entries=2, in_valid toggled with gaps of 2 idle cycles -> exactly 2 strobes, each 1 cycle after its transfer, in_stop=0 throughout LOAD.
REQ-023 num_entries=0 + load_start -> start_exec=1 in next cycle, no strobe, done=1 one cycle later.
REQ-024 context_max_id=2, word with in_ctx=3 (or PE_ROW_SIZE=3 with in_row=3) -> no strobe, error=1, in_stop=1; subsequent load_start clears error.
REQ-025 reset_n pulsed low after 1 of 4 words -> all outputs 0, in_stop=1, no start_exec until a new load completes.
REQ-026 load_start asserted during LOAD -> ignored; loaded_count and num_entries unchanged.
